mac_dot_engine: RTL

Parametrised multiply-accumulate engine for the matrix-multiply datapath. It computes one dot product of VEC_LEN element pairs per run. It adds the following over the earlier unsigned, free-running MAC:
- signed/unsigned mode
- valid/ready input handshake
- explicit run length
- saturating or wrapping accumulation with a sticky overflow flag
- a defined one-cycle result strobe

It sits between the operand fetch logic and the result writeback of the matrix unit.

---
 rtl/mac_pkg.sv | 36 +++
 rtl/mac_mul_stage.sv | 45 ++++
 rtl/mac_dot_engine.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the dot-product MAC engine: FSM encoding,
// compile-time log2 and the accumulator saturation limits.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Limits are returned as bit patterns; callers truncate to the accumulator width.
  function automatic logic [63:0] sat_max(input int w, input bit sgn);
    if (sgn) return (64'd1 << (w - 1)) - 64'd1;
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w, input bit sgn);
    if (sgn) return 64'd1 << (w - 1);
    return 64'd0;
  endfunction

endpackage

// File: rtl/mac_mul_stage.sv
// Registered IN_W x IN_W multiplier with a valid bit; flush drops any
// in-flight product so an aborted run never reaches the accumulator.
module mac_mul_stage
  import mac_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              en,
  input  logic [IN_W-1:0]   a,
  input  logic [IN_W-1:0]   b,
  output logic [2*IN_W-1:0] prod,
  output logic              prod_v
);

  logic [2*IN_W-1:0] mul;

  // Operands are widened to the product width first, so the low half of the
  // product is exact for both two's-complement and unsigned inputs.
  generate
    if (SIGNED) begin : g_signed
      assign mul = (2*IN_W)'($signed(a)) * (2*IN_W)'($signed(b));
    end else begin : g_unsigned
      assign mul = (2*IN_W)'(a) * (2*IN_W)'(b);
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod   <= '0;
      prod_v <= 1'b0;
    end else if (flush) begin
      prod_v <= 1'b0;
    end else begin
      prod_v <= en;
      if (en) prod <= mul;
    end
  end

endmodule

// File: rtl/mac_dot_engine.sv
// Dot-product engine: VEC_LEN operand pairs in via valid/ready, one result
// strobe out, with signed/unsigned mode and saturating or wrapping accumulation.
module mac_dot_engine
  import mac_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int VEC_LEN = 64,
  parameter int ACC_W   = 2*IN_W + clog2(VEC_LEN),
  parameter bit SIGNED  = 1'b0,
  parameter bit SAT     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overflow
);

  localparam int               CNT_W   = clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(VEC_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W, SIGNED));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W, SIGNED));

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic                ovf_next;
  logic                accept;
  logic [2*IN_W-1:0]   prod;
  logic                prod_v;
  logic [ACC_W:0]      acc_x;
  logic [ACC_W:0]      prod_x;
  logic [ACC_W:0]      sum;
  logic                sum_ovf;

  // start wins over a same-cycle operand: that operand belongs to no run.
  assign accept = in_valid & in_ready & ~start;

  mac_mul_stage #(
    .IN_W   (IN_W),
    .SIGNED (SIGNED)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .flush  (start),
    .en     (accept),
    .a      (a),
    .b      (b),
    .prod   (prod),
    .prod_v (prod_v)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    acc_next = acc;
    ovf_next = overflow;
    acc_x    = {SIGNED & acc[ACC_W-1], acc};
    prod_x   = {{(ACC_W + 1 - 2*IN_W){SIGNED & prod[2*IN_W-1]}}, prod};
    sum      = acc_x + prod_x;
    sum_ovf  = SIGNED ? (sum[ACC_W] != sum[ACC_W-1]) : sum[ACC_W];
    if (prod_v) begin
      acc_next = sum[ACC_W-1:0];
      if (sum_ovf) begin
        ovf_next = 1'b1;
        // The extra sum bit carries the true sign, which picks the clamp side.
        if (SAT) acc_next = (SIGNED && sum[ACC_W]) ? ACC_MIN : ACC_MAX;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      overflow  <= 1'b0;
      acc_out   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (start) begin
        // New run from any state; an unfinished run is abandoned.
        state    <= ACCUM;
        cnt      <= '0;
        acc      <= '0;
        overflow <= 1'b0;
        in_ready <= 1'b1;
        busy     <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          ACCUM: begin
            acc      <= acc_next;
            overflow <= ovf_next;
            if (accept) begin
              cnt <= cnt + 1'b1;
              if (cnt == LAST) begin
                state    <= DRAIN;
                in_ready <= 1'b0;
              end
            end
          end
          DRAIN: begin
            acc       <= acc_next;
            overflow  <= ovf_next;
            acc_out   <= acc_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
